// File: rtl/wb_regfile.sv
// wb_regfile
//   Back end of the integer pipeline: carries each EX result through the MEM
//   and WB registers and commits it to a 2**ADDR_W x DATA_W register file.
//   Two combinational read ports serve decode, with priority bypass from
//   EX, then MEM, then WB, then the array. Register 0 is hardwired to zero.
//
// Ports
//   clk, rst                         clock, synchronous active-low reset
//   ex_wd_i/ex_wreg_i/ex_wdata_i     EX result bus (dest, write enable, data)
//   stall_i                          hold MEM, push a bubble into WB
//   flush_i                          clear MEM and WB (overrides stall_i)
//   re1_i/raddr1_i/rdata1_o          read port 1
//   re2_i/raddr2_i/rdata2_o          read port 2
//   mem_wd_o/mem_wreg_o/mem_wdata_o  MEM-stage register contents
//   wb_wd_o/wb_wreg_o/wb_wdata_o     WB-stage register contents
//   commit_cnt_o                     count of architectural writes (wraps)
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [CNT_W-1:0]  commit_cnt_o
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              commit;

  // MEM and WB pipeline registers
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      mem_wd_o    <= '0;
      mem_wreg_o  <= 1'b0;
      mem_wdata_o <= '0;
      wb_wd_o     <= '0;
      wb_wreg_o   <= 1'b0;
      wb_wdata_o  <= '0;
    end else if (stall_i) begin
      wb_wd_o     <= '0;
      wb_wreg_o   <= 1'b0;
      wb_wdata_o  <= '0;
    end else begin
      mem_wd_o    <= ex_wd_i;
      mem_wreg_o  <= ex_wreg_i;
      mem_wdata_o <= ex_wdata_i;
      wb_wd_o     <= mem_wd_o;
      wb_wreg_o   <= mem_wreg_o;
      wb_wdata_o  <= mem_wdata_o;
    end
  end

  // WB content is already committed, so the array write ignores stall/flush.
  assign commit = wb_wreg_o && (wb_wd_o != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      commit_cnt_o <= '0;
    end else if (commit) begin
      regs[wb_wd_o] <= wb_wdata_o;
      commit_cnt_o  <= commit_cnt_o + CNT_W'(1);
    end
  end

  // Youngest in-flight producer wins; register 0 never bypasses.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              re,
    input logic [ADDR_W-1:0] ra
  );
    logic [DATA_W-1:0] d;
    d = '0;
    if (!rst || !re || ra == '0) begin
      d = '0;
    end else if (ex_wreg_i && ex_wd_i == ra) begin
      d = ex_wdata_i;
    end else if (mem_wreg_o && mem_wd_o == ra) begin
      d = mem_wdata_o;
    end else if (wb_wreg_o && wb_wd_o == ra) begin
      d = wb_wdata_o;
    end else begin
      d = regs[ra];
    end
    return d;
  endfunction

  always_comb begin
    rdata1_o = '0;
    rdata1_o = read_port(re1_i, raddr1_i);
  end

  always_comb begin
    rdata2_o = '0;
    rdata2_o = read_port(re2_i, raddr2_i);
  end

endmodule
